oled_rect_cmd_sender: RTL and testbench

//  Downstream of the rectangle command generator. Latches its 11-byte SSD1331 draw-rectangle

---
 rtl/oled_rect_cmd_sender.sv | 210 +++++++++++++++++++++
 tb/tb_oled_rect_cmd_sender.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_rect_cmd_sender.sv
// Shifts an optional SSD1331 clear-window frame, then the latched 11-byte draw-rectangle
// frame, out over 4-wire SPI mode 3 (MSB first, D/C held low), with a settle wait after each frame.
module oled_rect_cmd_sender #(
  parameter int CLK_DIV     = 4,
  parameter bit CLEAR_EN    = 1'b1,
  parameter int WAIT_CYCLES = 4000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [87:0] cmd_bytes,
  output logic        busy,
  output logic        done,
  output logic        oled_sclk,
  output logic        oled_mosi,
  output logic        oled_cs_n,
  output logic        oled_dc
);

  localparam int CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int WAIT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]  DIV_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_CS_SETUP, S_SHIFT, S_CS_HOLD, S_WAIT, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [2:0]          bit_q, bit_d;
  logic [3:0]          byte_q, byte_d;
  logic                rect_q, rect_d;
  logic                phase_q, phase_d;
  logic [87:0]         shadow_q, shadow_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic                cs_n_q, cs_n_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                accept;
  logic                advance;
  logic [3:0]          last_byte;
  logic [7:0]          cur_byte;

  // Byte idx of the active frame: fixed clear-window command, or the latched rectangle command.
  function automatic logic [7:0] frame_byte(input logic rect, input logic [3:0] idx,
                                            input logic [87:0] sh);
    logic [7:0] b;
    b = 8'h00;
    if (rect) begin
      for (int k = 0; k < 11; k++) begin
        if (idx == 4'(k)) b = sh[8*k +: 8];
      end
    end else begin
      case (idx)
        4'd0:    b = 8'h25;
        4'd3:    b = 8'h5F;
        4'd4:    b = 8'h3F;
        default: b = 8'h00;
      endcase
    end
    return b;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wait_d    = wait_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    rect_d    = rect_q;
    phase_d   = phase_q;
    shadow_d  = shadow_q;
    accept    = 1'b0;
    advance   = 1'b0;
    last_byte = rect_q ? 4'd10 : 4'd4;

    case (state_q)
      S_IDLE: begin
        if (start) accept = 1'b1;
      end
      S_CS_SETUP: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          phase_d = 1'b0;
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SHIFT: begin
        // phase 0 = sclk low half, phase 1 = sclk high half; the next bit starts on the fall
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else if (bit_q == 3'd0 && byte_q == last_byte) begin
            state_d = S_CS_HOLD;
          end else begin
            phase_d = 1'b0;
            bit_d   = bit_q - 3'd1;
            if (bit_q == 3'd0) byte_d = byte_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CS_HOLD: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (WAIT_CYCLES > 0) begin
            wait_d  = '0;
            state_d = S_WAIT;
          end else begin
            advance = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (wait_q == WAIT_LAST) advance = 1'b1;
        else wait_d = wait_q + WAIT_W'(1);
      end
      S_DONE: begin
        if (start) accept = 1'b1;
        else state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (!rect_q) begin
        rect_d  = 1'b1;
        byte_d  = 4'd0;
        bit_d   = 3'd7;
        cnt_d   = '0;
        state_d = S_CS_SETUP;
      end else begin
        state_d = S_DONE;
      end
    end

    if (accept) begin
      shadow_d = cmd_bytes;
      rect_d   = !CLEAR_EN;
      byte_d   = 4'd0;
      bit_d    = 3'd7;
      cnt_d    = '0;
      phase_d  = 1'b0;
      wait_d   = '0;
      state_d  = S_CS_SETUP;
    end

    // Pin levels follow the upcoming state so every output comes straight from a flop.
    cur_byte = frame_byte(rect_d, byte_d, shadow_d);
    cs_n_d   = !(state_d inside {S_CS_SETUP, S_SHIFT, S_CS_HOLD});
    sclk_d   = !(state_d == S_SHIFT && !phase_d);
    busy_d   = !(state_d inside {S_IDLE, S_DONE});
    done_d   = (state_d == S_DONE);
    if (state_d inside {S_CS_SETUP, S_SHIFT}) mosi_d = cur_byte[bit_d];
    else if (state_d == S_CS_HOLD) mosi_d = mosi_q;
    else mosi_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wait_q  <= '0;
      bit_q   <= 3'd0;
      byte_q  <= 4'd0;
      rect_q  <= 1'b0;
      phase_q <= 1'b0;
      sclk_q  <= 1'b1;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      rect_q  <= rect_d;
      phase_q <= phase_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Command data is not reset; a start coinciding with rst must not load it.
  always_ff @(posedge clk) begin
    if (!rst) shadow_q <= shadow_d;
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign oled_sclk = sclk_q;
  assign oled_mosi = mosi_q;
  assign oled_cs_n = cs_n_q;
  assign oled_dc   = 1'b0;

endmodule

// File: tb/tb_oled_rect_cmd_sender.sv
// Bench for oled_rect_cmd_sender: three parameterisations side by side, an SPI decoding
// monitor per instance, a table of directed sequences, hand-written corner cases and random runs.
module tb_oled_rect_cmd_sender;

  localparam int P_DIV[3]  = '{2, 2, 1};
  localparam int P_CLR[3]  = '{0, 1, 0};
  localparam int P_WAIT[3] = '{10, 10, 0};
  localparam logic [87:0] CMD1 = 88'h3E3F003E3F002F2F100022;
  localparam logic [87:0] CMD5 = 88'h3E3F003E3F002F5F100022;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  start;
  logic [87:0] cmd_in [3];
  logic [2:0]  busy, done, sclk, mosi, cs_n, dc;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  oled_rect_cmd_sender #(.CLK_DIV(2), .CLEAR_EN(1'b0), .WAIT_CYCLES(10)) u0 (
    .clk(clk), .rst(rst), .start(start[0]), .cmd_bytes(cmd_in[0]), .busy(busy[0]),
    .done(done[0]), .oled_sclk(sclk[0]), .oled_mosi(mosi[0]), .oled_cs_n(cs_n[0]), .oled_dc(dc[0]));
  oled_rect_cmd_sender #(.CLK_DIV(2), .CLEAR_EN(1'b1), .WAIT_CYCLES(10)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .cmd_bytes(cmd_in[1]), .busy(busy[1]),
    .done(done[1]), .oled_sclk(sclk[1]), .oled_mosi(mosi[1]), .oled_cs_n(cs_n[1]), .oled_dc(dc[1]));
  oled_rect_cmd_sender #(.CLK_DIV(1), .CLEAR_EN(1'b0), .WAIT_CYCLES(0)) u2 (
    .clk(clk), .rst(rst), .start(start[2]), .cmd_bytes(cmd_in[2]), .busy(busy[2]),
    .done(done[2]), .oled_sclk(sclk[2]), .oled_mosi(mosi[2]), .oled_cs_n(cs_n[2]), .oled_dc(dc[2]));

  // SPI slave view of each instance, sampled mid-cycle
  bit         mon_en = 1'b0;
  logic [2:0] p_sclk = '1, p_mosi = '0, p_cs_n = '1;
  logic [7:0] sh [3];
  logic [7:0] rx_buf [3][512];
  int         frm_len [3][64];
  int bitcnt[3], rx_n[3], rise_cnt[3], frm_n[3], cs_run[3], cs_hi[3], gap_last[3];
  int e_stab[3], e_mosi[3], e_idle[3], e_dc[3], e_bd[3];

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (mon_en) begin
        if (!cs_n[i] && p_cs_n[i]) begin
          gap_last[i] <= cs_hi[i];
          cs_run[i]   <= 1;
          bitcnt[i]   <= 0;
        end else if (!cs_n[i]) begin
          cs_run[i] <= cs_run[i] + 1;
          if (mosi[i] != p_mosi[i] && !(p_sclk[i] && !sclk[i])) e_mosi[i] <= e_mosi[i] + 1;
          if (sclk[i] && !p_sclk[i]) begin
            rise_cnt[i] <= rise_cnt[i] + 1;
            if (mosi[i] != p_mosi[i]) e_stab[i] <= e_stab[i] + 1;
            if (bitcnt[i] == 7) begin
              if (rx_n[i] < 512) rx_buf[i][rx_n[i]] <= {sh[i][6:0], mosi[i]};
              rx_n[i]   <= rx_n[i] + 1;
              bitcnt[i] <= 0;
            end else begin
              sh[i]     <= {sh[i][6:0], mosi[i]};
              bitcnt[i] <= bitcnt[i] + 1;
            end
          end
        end else begin
          if (!p_cs_n[i]) begin
            if (frm_n[i] < 64) frm_len[i][frm_n[i]] <= cs_run[i];
            frm_n[i] <= frm_n[i] + 1;
            cs_hi[i] <= 1;
          end else begin
            cs_hi[i] <= cs_hi[i] + 1;
          end
          if (!sclk[i]) e_idle[i] <= e_idle[i] + 1;
        end
        if (dc[i] !== 1'b0) e_dc[i] <= e_dc[i] + 1;
        if (done[i] && busy[i]) e_bd[i] <= e_bd[i] + 1;
      end
      p_sclk[i] <= sclk[i];
      p_mosi[i] <= mosi[i];
      p_cs_n[i] <= cs_n[i];
    end
  end

  int n_pass = 0, n_tot = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  function automatic logic [87:0] rnd88();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[87:0];
  endfunction

  // Cycles from the start cycle to done: one accept cycle plus each frame and its settle wait.
  function automatic int model_lat(input int i);
    int lat;
    lat = 1;
    if (P_CLR[i] != 0) lat += (2 + 16 * 5) * P_DIV[i] + P_WAIT[i];
    lat += (2 + 16 * 11) * P_DIV[i] + P_WAIT[i];
    return lat;
  endfunction

  // Call at #1 after a rising edge; returns mid-cycle in the done cycle.
  task automatic do_seq(input int i, input logic [87:0] c, input int exp_lat, input bit hammer);
    logic [7:0] eb [16];
    int n_exp, nf, b_rx, b_frm, b_rise, st, not_busy;
    bit got;
    n_exp = 0;
    if (P_CLR[i] != 0) begin
      eb[0] = 8'h25; eb[1] = 8'h00; eb[2] = 8'h00; eb[3] = 8'h5F; eb[4] = 8'h3F;
      n_exp = 5;
    end
    for (int k = 0; k < 11; k++) eb[n_exp + k] = c[8*k +: 8];
    n_exp += 11;
    nf = (P_CLR[i] != 0) ? 2 : 1;
    b_rx = rx_n[i]; b_frm = frm_n[i]; b_rise = rise_cnt[i];
    cmd_in[i] = c;
    start[i]  = 1'b1;
    st = cyc;
    @(posedge clk); #1;
    start[i] = 1'b0;
    chk($sformatf("busy_after_start u%0d", i), busy[i], 1);
    chk($sformatf("cs_fall_after_start u%0d", i), cs_n[i], 0);
    chk($sformatf("first_mosi u%0d", i), mosi[i], eb[0][7]);
    got = 1'b0;
    not_busy = 0;
    for (int n = 1; n < exp_lat + 100 && !got; n++) begin
      if (done[i]) begin
        got = 1'b1;
      end else begin
        if (!busy[i]) not_busy++;
        if (hammer) begin
          start[i]  = (cyc - st < 150);
          cmd_in[i] = rnd88();
        end
        @(posedge clk); #1;
      end
    end
    start[i] = 1'b0;
    chk($sformatf("done_seen u%0d", i), got, 1);
    if (got) begin
      @(negedge clk); #1;
      chk($sformatf("latency u%0d", i), cyc - st, exp_lat);
      chk($sformatf("busy_held u%0d", i), not_busy, 0);
      chk($sformatf("busy_in_done u%0d", i), busy[i], 0);
      chk($sformatf("byte_count u%0d", i), rx_n[i] - b_rx, n_exp);
      for (int k = 0; k < n_exp; k++)
        if (b_rx + k < 512) chk($sformatf("byte%0d u%0d", k, i), rx_buf[i][b_rx + k], eb[k]);
      chk($sformatf("frame_count u%0d", i), frm_n[i] - b_frm, nf);
      for (int f = 0; f < nf; f++)
        if (b_frm + f < 64)
          chk($sformatf("cs_low_len f%0d u%0d", f, i), frm_len[i][b_frm + f],
              (2 + 16 * ((nf == 2 && f == 0) ? 5 : 11)) * P_DIV[i]);
      chk($sformatf("sclk_rises u%0d", i), rise_cnt[i] - b_rise, 8 * n_exp);
      if (nf == 2) chk($sformatf("cs_gap u%0d", i), gap_last[i], P_WAIT[i]);
    end
  endtask

  typedef struct {
    int          inst;
    logic [87:0] cmd;
    int          lat;
  } vec_t;
  vec_t tbl [4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got %0d/%0d checks", n_pass, n_tot);
    $fatal(1);
  end

  initial begin
    int b, bad;
    bit found;
    tbl[0] = '{0, CMD1, 367};
    tbl[1] = '{1, CMD1, 541};
    tbl[2] = '{2, CMD1, 179};
    tbl[3] = '{0, CMD5, 367};
    rst = 1'b1;
    start = '0;
    for (int i = 0; i < 3; i++) cmd_in[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("reset_pins u%0d", i), {sclk[i], cs_n[i], mosi[i], busy[i], done[i], dc[i]}, 6'b110000);
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 4; t++) begin
      do_seq(tbl[t].inst, tbl[t].cmd, tbl[t].lat, 1'b0);
      repeat (3) @(posedge clk);
      #1;
    end

    // start held and command scrambled while busy: only the first command goes out, once
    do_seq(0, CMD1, 367, 1'b1);
    bad = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done[0] || busy[0]) bad++;
    end
    chk("no_extra_done", bad, 0);

    // back-to-back: second start lands in the done cycle
    do_seq(0, CMD1, 367, 1'b0);
    do_seq(0, CMD5, 367, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    // reset during byte 3, bit 5
    cmd_in[0] = CMD1;
    b = rx_n[0];
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 500 && !found; n++) begin
      if (rx_n[0] - b == 3 && bitcnt[0] == 2) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("reached_byte3_bit5", found, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_frame_reset_pins", {sclk[0], cs_n[0], mosi[0], busy[0], done[0]}, 5'b11000);
    @(posedge clk); #1;
    do_seq(0, CMD1, 367, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // rst and start together: nothing starts
    rst = 1'b1;
    start[0] = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    start[0] = 1'b0;
    bad = 0;
    repeat (5) begin
      if (busy[0] || !cs_n[0]) bad++;
      @(posedge clk); #1;
    end
    chk("rst_beats_start", bad, 0);

    for (int r = 0; r < 6; r++) begin
      int i;
      logic [87:0] c;
      i = int'($urandom_range(0, 2));
      c = rnd88();
      c[7:0] = 8'h22;
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #1;
      do_seq(i, c, model_lat(i), 1'b0);
      @(posedge clk); #1;
    end

    for (int i = 0; i < 3; i++) begin
      chk($sformatf("mosi_stable_at_rise u%0d", i), e_stab[i], 0);
      chk($sformatf("mosi_changes_on_fall u%0d", i), e_mosi[i], 0);
      chk($sformatf("sclk_high_when_idle u%0d", i), e_idle[i], 0);
      chk($sformatf("dc_low u%0d", i), e_dc[i], 0);
      chk($sformatf("done_busy_exclusive u%0d", i), e_bd[i], 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
